// File: rtl/sensor_pkg.sv
// Shared definitions for the ultrasonic ranging chain (ranger, distance filter, buzzer).
package sensor_pkg;

   localparam int DW_DEF     = 8;
   localparam int MIN_CM_DEF = 2;
   localparam int MAX_CM_DEF = 200;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_TRACK = 2'd1,
      S_STALE = 2'd2
   } filt_state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'hFF) begin
         r = v;
      end else begin
         r = v + 8'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/distance_filter_if.sv
// Raw-sample / filtered-result bundle between the ranger, the filter and its consumers.
interface distance_filter_if import sensor_pkg::*; #(
   parameter int DW = DW_DEF
) ();
   logic          in_valid;
   logic [DW-1:0] in_distance;
   logic          out_valid;
   logic [DW-1:0] out_distance;
   logic          out_stale;
   logic [7:0]    reject_count;

   modport master (
      output in_valid, in_distance,
      input  out_valid, out_distance, out_stale, reject_count
   );

   modport slave (
      input  in_valid, in_distance,
      output out_valid, out_distance, out_stale, reject_count
   );
endinterface

// File: rtl/dist_ring_buf.sv
// DEPTH x DW sample window: single-slot write at wr_ptr, or fill every slot at once (prime).
module dist_ring_buf import sensor_pkg::*; #(
   parameter int DW         = DW_DEF,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  wr_en,
   input  logic                  prime,
   input  logic [DEPTH_LOG2-1:0] wr_ptr,
   input  logic [DW-1:0]         wr_data,
   output logic [DW-1:0]         oldest
);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [DW-1:0] slot_r [DEPTH];

   // Slot storage; prime takes priority over a single-slot write
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            slot_r[i] <= '0;
         end
      end else if (prime) begin
         for (int i = 0; i < DEPTH; i++) begin
            slot_r[i] <= wr_data;
         end
      end else if (wr_en) begin
         slot_r[wr_ptr] <= wr_data;
      end
   end

   // The slot about to be overwritten is the oldest sample in the window
   assign oldest = slot_r[wr_ptr];

endmodule

// File: rtl/distance_filter.sv
// Range-gates raw ultrasonic samples, outputs a DEPTH-sample moving average and flags stale data.
module distance_filter import sensor_pkg::*; #(
   parameter int DW           = DW_DEF,
   parameter int DEPTH_LOG2   = 2,
   parameter int MIN_CM       = MIN_CM_DEF,
   parameter int MAX_CM       = MAX_CM_DEF,
   parameter int STALE_CYCLES = 25000000
) (
   input logic              clock,
   input logic              resetn,
   distance_filter_if.slave bus
);
   localparam int              SW        = DW + DEPTH_LOG2;
   localparam int              TW        = $clog2(STALE_CYCLES + 1);
   localparam logic [DW-1:0]   MIN_V     = DW'(MIN_CM);
   localparam logic [DW-1:0]   MAX_V     = DW'(MAX_CM);
   localparam logic [TW-1:0]   LIM_V     = TW'(STALE_CYCLES);
   localparam logic [TW-1:0]   PRE_LIM_V = TW'(STALE_CYCLES - 1);

   logic                  s1_valid_r;
   logic                  s1_ok_r;
   logic [DW-1:0]         s1_data_r;
   filt_state_e           state_r;
   filt_state_e           state_nxt_s;
   logic [SW-1:0]         sum_r;
   logic [SW-1:0]         sum_nxt_s;
   logic [TW-1:0]         timer_r;
   logic [TW-1:0]         timer_nxt_s;
   logic [DEPTH_LOG2-1:0] wr_ptr_r;
   logic [DW-1:0]         oldest_s;
   logic [7:0]            reject_count_r;
   logic                  out_valid_r;
   logic                  out_stale_r;
   logic [DW-1:0]         out_distance_r;
   logic                  in_range_s;
   logic                  accept_s;
   logic                  reject_s;
   logic                  prime_s;
   logic                  track_s;
   logic                  timer_hit_s;

   assign in_range_s  = (bus.in_distance >= MIN_V) && (bus.in_distance <= MAX_V);
   assign accept_s    = s1_valid_r & s1_ok_r;
   assign reject_s    = s1_valid_r & ~s1_ok_r;
   assign prime_s     = accept_s & (state_r != S_TRACK);
   assign track_s     = accept_s & (state_r == S_TRACK);
   assign timer_hit_s = (timer_r == PRE_LIM_V);

   // Stage 1: capture the sample together with its range verdict
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         s1_valid_r <= 1'b0;
         s1_ok_r    <= 1'b0;
         s1_data_r  <= '0;
      end else begin
         s1_valid_r <= bus.in_valid;
         s1_ok_r    <= in_range_s;
         s1_data_r  <= bus.in_distance;
      end
   end

   // Running sum and stale timer next values; an accepted sample always clears the timer
   always_comb begin
      sum_nxt_s   = sum_r;
      timer_nxt_s = timer_r;
      if (prime_s) begin
         sum_nxt_s = SW'(s1_data_r) << DEPTH_LOG2;
      end else if (track_s) begin
         sum_nxt_s = sum_r + SW'(s1_data_r) - SW'(oldest_s);
      end else begin
         sum_nxt_s = sum_r;
      end
      if (accept_s) begin
         timer_nxt_s = '0;
      end else if (timer_r < LIM_V) begin
         timer_nxt_s = timer_r + 1'b1;
      end else begin
         timer_nxt_s = timer_r;
      end
   end

   // Tracking state: any accepted sample wins over a simultaneous timeout
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_EMPTY: begin
            if (accept_s) state_nxt_s = S_TRACK;
            else          state_nxt_s = S_EMPTY;
         end
         S_TRACK: begin
            if (accept_s)         state_nxt_s = S_TRACK;
            else if (timer_hit_s) state_nxt_s = S_STALE;
            else                  state_nxt_s = S_TRACK;
         end
         S_STALE: begin
            if (accept_s) state_nxt_s = S_TRACK;
            else          state_nxt_s = S_STALE;
         end
         default: state_nxt_s = S_EMPTY;
      endcase
   end

   // FSM, sum, timer and window pointer registers
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_r  <= S_EMPTY;
         sum_r    <= '0;
         timer_r  <= '0;
         wr_ptr_r <= '0;
      end else begin
         state_r  <= state_nxt_s;
         sum_r    <= sum_nxt_s;
         timer_r  <= timer_nxt_s;
         if (track_s) begin
            wr_ptr_r <= wr_ptr_r + 1'b1;
         end
      end
   end

   // Stage 2 outputs; out_distance only moves on an accepted sample
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         out_valid_r    <= 1'b0;
         out_stale_r    <= 1'b1;
         out_distance_r <= '0;
         reject_count_r <= 8'd0;
      end else begin
         out_valid_r <= accept_s;
         out_stale_r <= (state_nxt_s != S_TRACK);
         if (accept_s) begin
            out_distance_r <= sum_nxt_s[SW-1:DEPTH_LOG2];
         end
         if (reject_s) begin
            reject_count_r <= sat_inc8(reject_count_r);
         end
      end
   end

   dist_ring_buf #(
      .DW         (DW),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ring (
      .clock   (clock),
      .resetn  (resetn),
      .wr_en   (track_s),
      .prime   (prime_s),
      .wr_ptr  (wr_ptr_r),
      .wr_data (s1_data_r),
      .oldest  (oldest_s)
   );

   assign bus.out_valid    = out_valid_r;
   assign bus.out_stale    = out_stale_r;
   assign bus.out_distance = out_distance_r;
   assign bus.reject_count = reject_count_r;

endmodule

// File: tb/tb_distance_filter.sv
// Directed bench for distance_filter: per-cycle window/queue model plus hand-computed pins.
module tb_distance_filter;
   localparam int STALE = 100;

   logic clock;
   logic resetn;
   int   n_cmp;
   int   n_bad;
   int   cyc;

   distance_filter_if #(.DW(8)) bus ();

   distance_filter #(.STALE_CYCLES(STALE)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus.slave)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Observations captured by the compare process for the directed pins
   int pulse_q[$];
   int pulse_cyc_q[$];
   int in_cyc_q[$];
   int last_pulse_cyc;
   int stale_rise_cyc;

   // Reference model state
   int win[$];
   int m_dist, m_rej, m_since;
   bit m_valid, m_stale;
   bit h_v0, h_v1;
   int h_d0, h_d1;

   initial begin
      bit prev_stale;
      bit ev_v;
      int ev_d;
      int total;
      cyc = 0;
      prev_stale = 1'b1;
      forever begin
         @(negedge clock);
         cyc++;
         if (!resetn) begin
            win.delete();
            m_dist = 0; m_rej = 0; m_since = 0; m_valid = 1'b0; m_stale = 1'b1;
            h_v0 = 1'b0; h_v1 = 1'b0; h_d0 = 0; h_d1 = 0;
         end else begin
            ev_v = h_v1; ev_d = h_d1;
            h_v1 = h_v0; h_d1 = h_d0;
            h_v0 = bus.in_valid; h_d0 = int'(bus.in_distance);
            if (bus.in_valid) in_cyc_q.push_back(cyc);
            m_valid = 1'b0;
            if (ev_v && ev_d >= 2 && ev_d <= 200) begin
               if (m_stale) begin
                  win = {ev_d, ev_d, ev_d, ev_d};
               end else begin
                  void'(win.pop_front());
                  win.push_back(ev_d);
               end
               total = 0;
               foreach (win[i]) total += win[i];
               m_dist = total / 4;
               m_valid = 1'b1; m_stale = 1'b0; m_since = 0;
            end else begin
               if (ev_v && m_rej < 255) m_rej++;
               if (m_since < STALE) m_since++;
               if (m_since >= STALE) m_stale = 1'b1;
            end
         end
         check("out_valid", int'(bus.out_valid), int'(m_valid));
         check("out_distance", int'(bus.out_distance), m_dist);
         check("out_stale", int'(bus.out_stale), int'(m_stale));
         check("reject_count", int'(bus.reject_count), m_rej);
         if (bus.out_valid) begin
            pulse_q.push_back(int'(bus.out_distance));
            pulse_cyc_q.push_back(cyc);
            last_pulse_cyc = cyc;
         end
         if (bus.out_stale && !prev_stale) stale_rise_cyc = cyc;
         prev_stale = bus.out_stale;
      end
   end

   task automatic drive(input bit v, input int d);
      @(posedge clock);
      #1;
      bus.in_valid    = v;
      bus.in_distance = 8'(d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 0);
   endtask

   task automatic pulse_reset();
      @(posedge clock);
      #1;
      resetn       = 1'b0;
      bus.in_valid = 1'b0;
      @(posedge clock);
      #1;
      resetn = 1'b1;
   endtask

   task automatic clear_obs();
      pulse_q.delete();
      pulse_cyc_q.delete();
      in_cyc_q.delete();
   endtask

   task automatic check_pulses(input string name, input int e[$]);
      check({name, "_count"}, pulse_q.size(), e.size());
      for (int i = 0; i < e.size() && i < pulse_q.size(); i++) begin
         check($sformatf("%s_val%0d", name, i), pulse_q[i], e[i]);
      end
   endtask

   initial begin
      int e[$];
      n_cmp = 0;
      n_bad = 0;
      resetn = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_distance = 8'd0;
      repeat (3) @(posedge clock);
      #1;
      resetn = 1'b1;

      // 1: first sample primes, appears two clocks later, stale clears
      idle(2);
      check("t1_stale_before", int'(bus.out_stale), 1);
      clear_obs();
      drive(1'b1, 100);
      idle(3);
      e = {100};
      check_pulses("t1", e);
      if (pulse_cyc_q.size() > 0 && in_cyc_q.size() > 0)
         check("t1_latency", pulse_cyc_q[0] - in_cyc_q[0], 2);
      check("t1_stale_after", int'(bus.out_stale), 0);

      // 2: window update from a primed buffer of 100s
      clear_obs();
      drive(1'b1, 104); drive(1'b0, 0);
      drive(1'b1, 108); drive(1'b0, 0);
      drive(1'b1, 112); drive(1'b0, 0);
      drive(1'b1, 116);
      idle(3);
      e = {101, 103, 106, 110};
      check_pulses("t2", e);

      // 3: out-of-range echoes
      clear_obs();
      drive(1'b1, 0); drive(1'b1, 250); drive(1'b1, 201);
      idle(3);
      e = {};
      check_pulses("t3", e);
      check("t3_rejects", int'(bus.reject_count), 3);
      check("t3_held", int'(bus.out_distance), 110);

      // 5: stale timeout, then a fresh sample re-primes
      idle(110);
      check("t5_stale_delay", stale_rise_cyc - last_pulse_cyc, STALE);
      check("t5_stale", int'(bus.out_stale), 1);
      check("t5_held", int'(bus.out_distance), 110);
      clear_obs();
      drive(1'b1, 50);
      idle(3);
      e = {50};
      check_pulses("t5", e);
      check("t5_fresh", int'(bus.out_stale), 0);

      // 4: back-to-back samples after reset
      pulse_reset();
      clear_obs();
      drive(1'b1, 10); drive(1'b1, 20); drive(1'b1, 30); drive(1'b1, 40);
      idle(3);
      e = {10, 12, 17, 25};
      check_pulses("t4", e);
      if (pulse_cyc_q.size() == 4)
         check("t4_span", pulse_cyc_q[3] - pulse_cyc_q[0], 3);

      // 6: reset while a sample is in flight
      clear_obs();
      drive(1'b1, 77);
      pulse_reset();
      idle(3);
      e = {};
      check_pulses("t6_flush", e);
      check("t6_dist", int'(bus.out_distance), 0);
      check("t6_stale", int'(bus.out_stale), 1);
      drive(1'b1, 60);
      idle(3);
      e = {60};
      check_pulses("t6_prime", e);

      // Range boundaries: 1 and 201 rejected, 2 and 200 accepted
      pulse_reset();
      clear_obs();
      drive(1'b1, 1); drive(1'b1, 2); drive(1'b1, 200); drive(1'b1, 201);
      idle(3);
      e = {2, 51};
      check_pulses("tb", e);
      check("tb_rejects", int'(bus.reject_count), 2);

      // 7: reject counter saturation
      clear_obs();
      for (int i = 0; i < 300; i++) drive(1'b1, 255);
      idle(3);
      check("t7_sat", int'(bus.reject_count), 255);
      check("t7_held", int'(bus.out_distance), 51);
      e = {};
      check_pulses("t7", e);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
